// File: rtl/sdiv_pkg.sv
// Shared types and helpers for the sequenced signed divider.
package sdiv_pkg;

    localparam int unsigned SDIV_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } sdiv_state_t;

    // Two's complement negate on a zero-extended operand; caller truncates to its width.
    function automatic logic [31:0] sdiv_neg(input logic [31:0] x);
        return 32'(~x + 32'd1);
    endfunction

    // Magnitude of a zero-extended operand whose sign bit is passed separately.
    function automatic logic [31:0] sdiv_abs(input logic [31:0] x, input logic neg);
        return neg ? sdiv_neg(x) : x;
    endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring division iteration: shift {rem, q} left and conditionally subtract d_mag.
module sdiv_step
    import sdiv_pkg::*;
#(
    parameter int unsigned W = SDIV_W
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] q,
    input  logic [W-1:0] d_mag,
    output logic [W:0]   rem_n,
    output logic [W-1:0] q_n
);

    localparam int unsigned SW = W + 2;

    logic [SW-1:0] shifted;
    logic [SW-1:0] d_ext;

    always_comb begin
        shifted = {rem, q[W-1]};
        d_ext   = SW'(d_mag);
        q_n     = {q[W-2:0], 1'b0};
        rem_n   = (W+1)'(shifted);
        if (shifted >= d_ext) begin
            rem_n   = (W+1)'(shifted - d_ext);
            q_n[0]  = 1'b1;
        end
    end

endmodule

// File: rtl/sdiv_seq_ctrl.sv
// Sequenced signed divider: handshake FSM around an iterative restoring datapath.
// Optional feature macro: SDIV_DBZ_FLAG_EN adds the dbz divide-by-zero output.
module sdiv_seq_ctrl
    import sdiv_pkg::*;
#(
    parameter int unsigned W = SDIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
`ifdef SDIV_DBZ_FLAG_EN
    ,
    output logic         dbz
`endif
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    sdiv_state_t state, state_n;

    logic [W-1:0]     a_reg, b_reg;
    logic [W-1:0]     a_mag_c, b_mag_c;
    logic [W-1:0]     d_mag, q_mag;
    logic [W:0]       rem;
    logic [W:0]       rem_step;
    logic [W-1:0]     q_step;
    logic [CNT_W-1:0] count;
    logic             sign_q, sign_r, dbz_case;

    sdiv_step #(.W(W)) u_step (
        .rem   (rem),
        .q     (q_mag),
        .d_mag (d_mag),
        .rem_n (rem_step),
        .q_n   (q_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        a_mag_c = W'(sdiv_abs(32'(a_reg), a_reg[W-1]));
        b_mag_c = W'(sdiv_abs(32'(b_reg), b_reg[W-1]));
        case (state)
            IDLE:    if (in_valid) state_n = LOAD;
            LOAD:    state_n = (b_reg == '0) ? FIX : CALC;
            CALC:    if (count == CNT_W'(1)) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            d_mag     <= '0;
            q_mag     <= '0;
            rem       <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dbz_case  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SDIV_DBZ_FLAG_EN
            dbz       <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= dividend;
                        b_reg <= divisor;
                    end
                end
                LOAD: begin
                    d_mag    <= b_mag_c;
                    sign_q   <= a_reg[W-1] ^ b_reg[W-1];
                    sign_r   <= a_reg[W-1];
                    dbz_case <= (b_reg == '0);
                    count    <= CNT_W'(W);
                    if (b_reg == '0) begin
                        q_mag <= '1;
                        rem   <= {1'b0, a_mag_c};
                    end else begin
                        q_mag <= a_mag_c;
                        rem   <= '0;
                    end
                end
                CALC: begin
                    rem   <= rem_step;
                    q_mag <= q_step;
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    // Divide-by-zero forces -1 whatever the operand signs were.
                    quotient  <= dbz_case ? '1 :
                                 (sign_q ? W'(sdiv_neg(32'(q_mag))) : q_mag);
                    remainder <= sign_r ? W'(sdiv_neg(32'(rem[W-1:0]))) : rem[W-1:0];
`ifdef SDIV_DBZ_FLAG_EN
                    dbz       <= dbz_case;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdiv_seq_ctrl.sv
// Directed and randomized self-checking bench for sdiv_seq_ctrl at W=9.
module tb_sdiv_seq_ctrl;

    localparam int unsigned W = 9;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef SDIV_DBZ_FLAG_EN
    logic         dbz;
`endif

    int n_checks;
    int n_fail;

    sdiv_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef SDIV_DBZ_FLAG_EN
        ,
        .dbz       (dbz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input int a, input int b);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        dividend = W'(a);
        divisor  = W'(b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_flags: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
            n_fail++;
        end
        n_checks++;
        if (quotient !== '0 || remainder !== '0) begin
            $display("FAIL reset_data: q=%h r=%h, required 000 000", quotient, remainder);
            n_fail++;
        end
`ifdef SDIV_DBZ_FLAG_EN
        n_checks++;
        if (dbz !== 1'b0) begin
            $display("FAIL reset_dbz: dbz=%b, required 0", dbz);
            n_fail++;
        end
`endif
    endtask

    task automatic test_signs();
        int ta[5] = '{100, -100, 100, -100, -256};
        int tb[5] = '{7, 7, -7, -7, -1};
        int tq[5] = '{14, -14, -14, 14, -256};
        int tr[5] = '{2, -2, 2, -2, 0};
        int cyc;
        for (int i = 0; i < 5; i++) begin
            start_op(ta[i], tb[i]);
            wait_valid(cyc);
            n_checks++;
            if (cyc != 11) begin
                $display("FAIL latency_%0d: %0d cycles, required 11", i, cyc);
                n_fail++;
            end
            n_checks++;
            if (quotient !== W'(tq[i]) || remainder !== W'(tr[i])) begin
                $display("FAIL div_%0d: q=%h r=%h, required q=%h r=%h",
                         i, quotient, remainder, W'(tq[i]), W'(tr[i]));
                n_fail++;
            end
`ifdef SDIV_DBZ_FLAG_EN
            n_checks++;
            if (dbz !== 1'b0) begin
                $display("FAIL dbz_clear_%0d: dbz=%b, required 0", i, dbz);
                n_fail++;
            end
`endif
            take_result();
        end
    endtask

    task automatic test_div_by_zero();
        int cyc;
        start_op(5, 0);
        wait_valid(cyc);
        n_checks++;
        if (cyc != 2) begin
            $display("FAIL dbz_latency: %0d cycles, required 2", cyc);
            n_fail++;
        end
        n_checks++;
        if (quotient !== 9'h1FF || remainder !== 9'd5) begin
            $display("FAIL dbz_pos: q=%h r=%h, required q=1ff r=005", quotient, remainder);
            n_fail++;
        end
`ifdef SDIV_DBZ_FLAG_EN
        n_checks++;
        if (dbz !== 1'b1) begin
            $display("FAIL dbz_flag: dbz=%b, required 1", dbz);
            n_fail++;
        end
`endif
        take_result();
        start_op(-7, 0);
        wait_valid(cyc);
        n_checks++;
        if (quotient !== 9'h1FF || remainder !== 9'h1F9) begin
            $display("FAIL dbz_neg: q=%h r=%h, required q=1ff r=1f9", quotient, remainder);
            n_fail++;
        end
        take_result();
        start_op(5, 1);
        wait_valid(cyc);
        n_checks++;
        if (quotient !== 9'd5 || remainder !== 9'd0) begin
            $display("FAIL after_dbz: q=%h r=%h, required q=005 r=000", quotient, remainder);
            n_fail++;
        end
`ifdef SDIV_DBZ_FLAG_EN
        n_checks++;
        if (dbz !== 1'b0) begin
            $display("FAIL dbz_flag_clear: dbz=%b, required 0", dbz);
            n_fail++;
        end
`endif
        take_result();
    endtask

    task automatic test_stall();
        int cyc;
        start_op(37, -5);
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            // Competing operands while busy must be ignored.
            in_valid = 1'b1;
            dividend = 9'd1;
            divisor  = 9'd1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                quotient !== 9'h1F9 || remainder !== 9'd2) begin
                $display("FAIL stall_%0d: ov=%b ir=%b q=%h r=%h, required 1 0 1f9 002",
                         i, out_valid, in_ready, quotient, remainder);
                n_fail++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        take_result();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            quotient !== 9'h1F9 || remainder !== 9'd2) begin
            $display("FAIL release: ov=%b ir=%b q=%h r=%h, required 0 1 1f9 002",
                     out_valid, in_ready, quotient, remainder);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op(100, 7);
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL busy_before_rst: in_ready=%b, required 0", in_ready);
            n_fail++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL mid_rst: ov=%b ir=%b, required 0 1", out_valid, in_ready);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL aborted_result: ov=%b, required 0", out_valid);
            n_fail++;
        end
        start_op(9, 3);
        wait_valid(cyc);
        n_checks++;
        if (cyc != 11 || quotient !== 9'd3 || remainder !== 9'd0) begin
            $display("FAIL post_rst: cyc=%0d q=%h r=%h, required 11 003 000", cyc, quotient, remainder);
            n_fail++;
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        localparam int NPAIRS = 2000;
        logic signed [W-1:0] sa, sb;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_r[$];
        logic [W-1:0] eq, er;
        bit pend;
        int sent, got, cycles;
        pend = 0; sent = 0; got = 0; cycles = 0;
        sa = '0; sb = 9'sd1;
        while (got < NPAIRS && cycles < 60000) begin
            if (!pend && sent < NPAIRS) begin
                sa = W'($urandom_range(0, 511));
                sb = W'($urandom_range(1, 511));
                pend = 1;
            end
            in_valid  = pend && ($urandom_range(0, 3) != 0);
            dividend  = sa;
            divisor   = sb;
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(W'(sa / sb));
                exp_r.push_back(W'(sa % sb));
                pend = 0;
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_spurious: unexpected result q=%h r=%h", quotient, remainder);
                    n_fail++;
                end else begin
                    eq = exp_q.pop_front();
                    er = exp_r.pop_front();
                    if (quotient !== eq || remainder !== er) begin
                        $display("FAIL rand_%0d: q=%h r=%h, required q=%h r=%h",
                                 got, quotient, remainder, eq, er);
                        n_fail++;
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (got != NPAIRS) begin
            $display("FAIL rand_timeout: %0d results, required %0d", got, NPAIRS);
            n_fail++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_signs();
        test_div_by_zero();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
